// File: rtl/clkmon_pkg.sv
// Shared types and elaboration checks for the clkmon
// clock/strobe monitor.
package clkmon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOST
   } state_t;

   function automatic bit params_ok(
      input int     cnt_w,
      input int     sync_stages,
      input longint timeout
   );
      bit ok;
      ok = (cnt_w >= 1) && (cnt_w < 63);
      ok = ok && (sync_stages >= 2) && (timeout >= 1);
      if (ok) ok = timeout < (longint'(1) << cnt_w);
      return ok;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus
// an edge register producing single-cycle rise/fall pulses.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              s;
   logic              s_d;

   assign s    = sync[STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync <= '0;
         s_d  <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         s_d  <= s;
      end
   end

endmodule

// File: rtl/clkmon.sv
// Measures period and high time of a slow wave in clk
// cycles and reports locked / lost status.
module clkmon
   import clkmon_pkg::*;
#(
   parameter int CNT_W       = 31,
   parameter int SYNC_STAGES = 2,
   parameter int EXP_PERIOD  = 488,
   parameter int TOL         = 2,
   parameter int LOCK_CNT    = 4,
   parameter int TIMEOUT     = 4096
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sig_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             locked,
   output logic             lost
);

   localparam int LR_W = $clog2(LOCK_CNT + 1);
   localparam logic [LR_W-1:0]  LOCK_MAX = LR_W'(LOCK_CNT);
   localparam logic [CNT_W:0]   EXP_V    = (CNT_W+1)'(EXP_PERIOD);
   localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   if (!params_ok(CNT_W, SYNC_STAGES, longint'(TIMEOUT))) begin : g_bad
      $error("clkmon: need TIMEOUT < 2**CNT_W, SYNC_STAGES >= 2");
   end

   logic             rise;
   logic             fall;
   state_t           state;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cap;
   logic [LR_W-1:0]  lock_run;
   logic [CNT_W-1:0] per_inc;
   logic [CNT_W:0]   per_ext;
   logic [CNT_W:0]   diff;
   logic             in_tol;
   logic [LR_W-1:0]  run_nxt;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .din  (sig_in),
      .rise (rise),
      .fall (fall)
   );

   // Lock decision uses the period being reported this cycle.
   assign per_inc = per_cnt + CNT_W'(1);
   assign per_ext = {1'b0, per_inc};
   assign diff    = (per_ext >= EXP_V) ? per_ext - EXP_V
                                       : EXP_V - per_ext;
   assign in_tol  = diff <= TOL_V;
   assign run_nxt = (lock_run == LOCK_MAX) ? lock_run
                                           : lock_run + LR_W'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         per_cnt    <= '0;
         hi_cap     <= '0;
         lock_run   <= '0;
         meas_valid <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state   <= MEASURE;
                  per_cnt <= '0;
                  hi_cap  <= '0;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period     <= per_inc;
                  high_time  <= hi_cap;
                  meas_valid <= 1'b1;
                  per_cnt    <= '0;
                  if (in_tol) begin
                     lock_run <= run_nxt;
                     if (run_nxt == LOCK_MAX) locked <= 1'b1;
                  end else begin
                     lock_run <= '0;
                     locked   <= 1'b0;
                  end
               end else begin
                  per_cnt <= per_inc;
                  if (per_cnt == TMO_LAST) begin
                     state    <= LOST;
                     lost     <= 1'b1;
                     locked   <= 1'b0;
                     lock_run <= '0;
                  end
               end
               if (fall) hi_cap <= per_inc;
            end
            LOST: begin
               // This edge restarts timing; nothing is reported.
               if (rise) begin
                  state   <= MEASURE;
                  lost    <= 1'b0;
                  per_cnt <= '0;
                  hi_cap  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/clkmon.md
# clkmon

Clock/strobe monitor that measures an incoming slow square wave (typically a divided clock produced on-chip or an external reference) against the system clock. It synchronizes the input, times its period and high time in system-clock cycles, reports each completed measurement, and raises `locked` / `lost` status for board-level LEDs and the MCU status register. It is the checking end of the clock-divider path: the divider generates the wave, and this block verifies it.

## Interface
- `CNT_W`, 31, width of the period/high-time counters and outputs.
- `SYNC_STAGES`, 2, synchronizer flops on `sig_in` (≥2).
- `EXP_PERIOD`, 488, expected period in `clk` cycles.
- `TOL`, 2, allowed |period − EXP_PERIOD| for an in-tolerance period.
- `LOCK_CNT`, 4, consecutive in-tolerance periods required to assert `locked`.
- `TIMEOUT`, 4096, cycles without a rising edge before `lost`; must be < 2^CNT_W.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `sig_in` in 1: monitored wave, asynchronous to `clk`.
- `meas_valid` out 1: one-cycle pulse when `period`/`high_time` update.
- `period` out CNT_W: last measured period, in cycles.
- `high_time` out CNT_W: high time within that period, in cycles.
- `locked` out 1: period stable and in tolerance.
- `lost` out 1: no rising edge within TIMEOUT.

## Operation
- `sig_in` passes through SYNC_STAGES flops, then one edge register. `rise = s & ~s_d`, `fall = ~s & s_d`. Both are single-cycle pulses and never occur in the same cycle.
- State machine states: IDLE (reset), MEASURE, LOST.
  - IDLE: `fall` is ignored. On `rise`, go to MEASURE and set `per_cnt <= 0`. No `meas_valid` is issued (reference edge only).
  - MEASURE, each cycle:
    - On `rise`: `period <= per_cnt+1`, `high_time <= hi_cap`, pulse `meas_valid`, `per_cnt <= 0`.
    - Else: `per_cnt <= per_cnt+1`.
    - On `fall`: `hi_cap <= per_cnt+1`.
    - If `per_cnt == TIMEOUT-1` and no `rise` that cycle: go to LOST, `lost <= 1`, `locked <= 0`, `lock_run <= 0`.
  - LOST: counters are held. On `rise`, go to MEASURE, `lost <= 0`, `per_cnt <= 0`. No `meas_valid` is issued, because that edge is the new reference.
- If no `fall` occurs in a period (stuck-high pulse train impossible without a fall), `high_time` reports the last captured `hi_cap`. `hi_cap` is cleared to 0 on entry to MEASURE.
- Lock tracking runs on each `meas_valid`:
  - diff = |period − EXP_PERIOD|, computed in CNT_W+1 bits, unsigned.
  - diff ≤ TOL: `lock_run` increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, `locked <= 1`.
  - Otherwise: `lock_run <= 0`, `locked <= 0`, in the same cycle as that `meas_valid`.
- Arithmetic: counters are unsigned. TIMEOUT < 2^CNT_W guarantees `per_cnt` never wraps.

## Timing
- Reset values: `meas_valid`=0, `period`=0, `high_time`=0, `locked`=0, `lost`=0. State IDLE, all counters 0.
- Latency from a `sig_in` edge to the `rise`/`fall` pulse is SYNC_STAGES+1 cycles. Measured values are insensitive to this latency because it is constant.
- `meas_valid` and the new `period`/`high_time` appear in the cycle after the `rise` pulse. Values hold until the next `meas_valid`.
- Rise pulses at t0 and t0+P give `period`=P. A fall pulse at t0+H gives `high_time`=H.
- `lost` asserts TIMEOUT+1 cycles after the last `rise` pulse. A period of exactly TIMEOUT is measured normally, because `rise` wins over the timeout.
- `locked` asserts in the same cycle as the LOCK_CNT-th consecutive in-tolerance `meas_valid`.
- Reset mid-measurement clears all outputs and state immediately. The first rise after reset is a reference edge only.

## Structure
- Shared package `clkmon_pkg`: state enum (IDLE, MEASURE, LOST) and a parameter-check function asserting TIMEOUT < 2^CNT_W and SYNC_STAGES ≥ 2.
- One sub-module, `sync_edge`: the SYNC_STAGES synchronizer plus edge register, outputting `rise`/`fall`.
- Top level contains the FSM, counters and lock logic. Target size is roughly 150–250 lines.

## Test plan
- `sig_in` driven by an even divider, period 4, high 2; EXP_PERIOD=4, TOL=0, LOCK_CNT=4 -> `meas_valid` every 4 cycles with `period`=4, `high_time`=2; `locked` rises with the 4th `meas_valid`.
- `sig_in` at period 5, high 3 (odd-divider shape) -> `period`=5, `high_time`=3 on every `meas_valid`; no `meas_valid` from the first rise.
- While locked, hold `sig_in` low, TIMEOUT=64 -> `lost`=1 and `locked`=0 exactly 65 cycles after the last `rise`. Resume toggling -> `lost` clears on the first rise, and the first `meas_valid` comes one period later.
- Period steps from 4 to 6 with EXP_PERIOD=4, TOL=1 -> `locked` drops in the cycle of the first `meas_valid` with `period`=6.
- Period exactly TIMEOUT=64 -> `period`=64 reported and `lost` never asserts.
- Assert `rstn` low mid-period, then release -> all outputs 0 during reset; the first rise afterwards gives no `meas_valid`, and the second gives a correct `period`.
